// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants, redirect-source enum and alignment helper for the fetch stage
package pipeline_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_J    = 2'd2,
    REDIR_JR   = 2'd3
  } redir_src_e;

  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - live redirect priority select plus the stall-pending redirect register
module fetch_redirect_unit
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [PC_W-1:0] pc_plus4,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            jr,
  input  logic [PC_W-1:0] jr_target,
  output logic [PC_W-1:0] next_pc,
  output logic            apply_redirect,
  output logic            redirect_pending
);

  redir_src_e      live_src;
  logic [PC_W-1:0] live_target;
  logic [PC_W-1:0] pending_target;
  logic            redir;

  // jr outranks jump, which outranks a conditional branch
  always_comb begin
    live_src = REDIR_NONE;
    if (jr)
      live_src = REDIR_JR;
    else if (jump)
      live_src = REDIR_J;
    else if (branch_taken)
      live_src = REDIR_BR;
  end

  always_comb begin
    live_target = '0;
    case (live_src)
      REDIR_JR: live_target = align_word(jr_target);
      REDIR_J:  live_target = align_word(jump_target);
      REDIR_BR: live_target = align_word(branch_target);
      default:  live_target = '0;
    endcase
  end

  assign redir          = (live_src != REDIR_NONE);
  assign apply_redirect = !stall && (redir || redirect_pending);

  always_comb begin
    next_pc = pc_plus4;
    if (redir)
      next_pc = live_target;
    else if (redirect_pending)
      next_pc = pending_target;
  end

  // Newest redirect seen during a stall wins; any unstalled edge consumes it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_pending <= 1'b0;
      pending_target   <= '0;
    end else if (stall) begin
      if (redir) begin
        redirect_pending <= 1'b1;
        pending_target   <= live_target;
      end
    end else begin
      redirect_pending <= 1'b0;
      pending_target   <= '0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction fetch: PC register, imem address and IF/ID pipeline register
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter bit          DELAY_SLOT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        redirect_pending
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] next_pc;
  logic            apply_redirect;
  logic            load_bubble;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  fetch_redirect_unit u_redirect (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .pc_plus4         (pc_plus4),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .jr               (jr),
    .jr_target        (jr_target),
    .next_pc          (next_pc),
    .apply_redirect   (apply_redirect),
    .redirect_pending (redirect_pending)
  );

  // Without a delay slot the word fetched alongside a redirect is on the wrong path
  assign load_bubble = flush || (apply_redirect && !DELAY_SLOT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pc <= RESET_PC;
    else if (!stall)
      pc <= next_pc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (load_bubble) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc_plus4 <= '0;
      if_id_valid    <= 1'b0;
    end else if (!stall) begin
      if_id_instr    <= imem_instr;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        redirect_pending;

  int checks = 0;
  int errors = 0;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .DELAY_SLOT (1'b0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .jr               (jr),
    .jr_target        (jr_target),
    .imem_addr        (imem_addr),
    .imem_instr       (imem_instr),
    .pc               (pc),
    .if_id_instr      (if_id_instr),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory stand-in: two fixed words, elsewhere address ^ A500_0000
  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_instr = 32'h2002_0010;
      32'h0000_0004: imem_instr = 32'h0000_2020;
      default:       imem_instr = imem_addr ^ 32'hA500_0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_redirects();
    branch_taken = 1'b0;
    jump         = 1'b0;
    jr           = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;
    jr = 1'b0; jr_target = '0;
    #12;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pp4", if_id_pc_plus4, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    check("rst_pend", {31'b0, redirect_pending}, 32'h0);
    reset = 1'b0;

    check("run_addr0", imem_addr, 32'h0);
    step();
    check("run_pc4", pc, 32'h4);
    check("run_instr0", if_id_instr, 32'h2002_0010);
    check("run_pp4_0", if_id_pc_plus4, 32'h4);
    check("run_valid0", {31'b0, if_id_valid}, 32'h1);
    step();
    check("run_pc8", pc, 32'h8);
    check("run_instr4", if_id_instr, 32'h0000_2020);
    check("run_pp4_4", if_id_pc_plus4, 32'h8);

    branch_taken = 1'b1; branch_target = 32'h0000_0014;
    step();
    clear_redirects();
    check("br_pc", pc, 32'h14);
    check("br_bubble_valid", {31'b0, if_id_valid}, 32'h0);
    check("br_bubble_instr", if_id_instr, 32'h0);
    check("br_bubble_pp4", if_id_pc_plus4, 32'h0);
    step();
    check("br_fetch_pc", pc, 32'h18);
    check("br_fetch_instr", if_id_instr, 32'hA500_0014);
    check("br_fetch_pp4", if_id_pc_plus4, 32'h18);

    stall = 1'b1; jump = 1'b1; jump_target = 32'h40;
    step();
    clear_redirects();
    check("stj_pc_hold", pc, 32'h18);
    check("stj_pend", {31'b0, redirect_pending}, 32'h1);
    check("stj_ifid_hold", if_id_instr, 32'hA500_0014);
    step();
    step();
    check("stj_pc_hold3", pc, 32'h18);
    check("stj_pend3", {31'b0, redirect_pending}, 32'h1);
    stall = 1'b0;
    step();
    check("stj_pc_rel", pc, 32'h40);
    check("stj_pend_clr", {31'b0, redirect_pending}, 32'h0);
    check("stj_bubble", {31'b0, if_id_valid}, 32'h0);
    step();
    check("stj_next", pc, 32'h44);

    stall = 1'b1; jump = 1'b1; jump_target = 32'h40;
    step();
    clear_redirects();
    jr = 1'b1; jr_target = 32'h60;
    step();
    clear_redirects();
    stall = 1'b0;
    step();
    check("newest_wins", pc, 32'h60);

    jr = 1'b1; jr_target = 32'h3C;
    jump = 1'b1; jump_target = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h10;
    step();
    clear_redirects();
    check("prio_jr", pc, 32'h3C);
    jump = 1'b1; jump_target = 32'h80;
    branch_taken = 1'b1; branch_target = 32'h10;
    step();
    clear_redirects();
    check("prio_j", pc, 32'h80);

    jump = 1'b1; jump_target = 32'h0000_0023;
    step();
    clear_redirects();
    check("align", pc, 32'h20);
    step();
    check("align_next", pc, 32'h24);
    check("align_valid", {31'b0, if_id_valid}, 32'h1);
    check("align_instr", if_id_instr, 32'hA500_0020);

    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    check("flst_pc", pc, 32'h24);
    check("flst_valid", {31'b0, if_id_valid}, 32'h0);
    check("flst_instr", if_id_instr, 32'h0);

    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    clear_redirects();
    check("wrap_pc_top", pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc", pc, 32'h0);
    check("wrap_pp4", if_id_pc_plus4, 32'h0);
    check("wrap_valid", {31'b0, if_id_valid}, 32'h1);
    check("wrap_instr", if_id_instr, 32'h5AFF_FFFC);
    step();
    step();
    check("pre_rst_pc", pc, 32'h8);

    stall = 1'b1; jump = 1'b1; jump_target = 32'h100;
    step();
    clear_redirects();
    check("rstp_pend", {31'b0, redirect_pending}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("rstp_pc", pc, 32'h0);
    check("rstp_pend_clr", {31'b0, redirect_pending}, 32'h0);
    check("rstp_valid", {31'b0, if_id_valid}, 32'h0);
    check("rstp_instr", if_id_instr, 32'h0);
    stall = 1'b0;
    #2 reset = 1'b0;
    step();
    check("rstp_resume_pc", pc, 32'h4);
    check("rstp_resume_instr", if_id_instr, 32'h2002_0010);
    check("rstp_resume_pend", {31'b0, redirect_pending}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
